// File: rtl/op_defs_pkg.sv
// -----------------------------------------------------------------------------
// op_defs_pkg
// Shared definitions for the op_sequencer execute/writeback controller:
// datapath sizes, opcode encodings, status-flag bit positions, FSM state
// encodings and the small opcode decode helpers used by the sequencer.
// -----------------------------------------------------------------------------
package op_defs_pkg;

   localparam int DW    = 16;  // datapath / register width
   localparam int NREG  = 16;  // registers in the bank
   localparam int IDXW  = 4;   // log2(NREG)
   localparam int IMMW  = 8;   // immediate field width
   localparam int OPW   = 4;   // opcode width
   localparam int NFLAG = 5;   // {C,L,F,Z,N}

   localparam logic [OPW-1:0] OP_ADD  = 4'd0;
   localparam logic [OPW-1:0] OP_ADDI = 4'd1;
   localparam logic [OPW-1:0] OP_SUB  = 4'd2;
   localparam logic [OPW-1:0] OP_SUBI = 4'd3;
   localparam logic [OPW-1:0] OP_CMP  = 4'd4;
   localparam logic [OPW-1:0] OP_CMPI = 4'd5;
   localparam logic [OPW-1:0] OP_AND  = 4'd6;
   localparam logic [OPW-1:0] OP_OR   = 4'd7;
   localparam logic [OPW-1:0] OP_XOR  = 4'd8;
   localparam logic [OPW-1:0] OP_MOV  = 4'd9;
   localparam logic [OPW-1:0] OP_MOVI = 4'd10;
   localparam logic [OPW-1:0] OP_LSH  = 4'd11;
   localparam logic [OPW-1:0] OP_LSHI = 4'd12;

   localparam int FLAG_C = 4;  // carry / borrow
   localparam int FLAG_L = 3;  // unsigned less-than
   localparam int FLAG_F = 2;  // signed overflow
   localparam int FLAG_Z = 1;  // equal
   localparam int FLAG_N = 0;  // signed less-than

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2,
      S_WB    = 2'd3
   } state_t;

   // Operand B comes from the immediate field rather than the register bank.
   function automatic logic is_imm(input logic [OPW-1:0] op);
      return op inside {OP_ADDI, OP_SUBI, OP_CMPI, OP_MOVI, OP_LSHI};
   endfunction

   // Opcodes 13-15 are undefined and execute as a NOP.
   function automatic logic is_illegal(input logic [OPW-1:0] op);
      return op > OP_LSHI;
   endfunction

   // The op writes its result back to rdest.
   function automatic logic is_write(input logic [OPW-1:0] op);
      return !is_illegal(op) && !(op inside {OP_CMP, OP_CMPI});
   endfunction

   // Arithmetic immediates are signed; MOVI/LSHI immediates are unsigned.
   function automatic logic sign_ext(input logic [OPW-1:0] op);
      return op inside {OP_ADDI, OP_SUBI, OP_CMPI};
   endfunction

   function automatic logic [DW-1:0] ext_imm(input logic [OPW-1:0] op,
                                             input logic [IMMW-1:0] imm);
      return {{(DW-IMMW){sign_ext(op) & imm[IMMW-1]}}, imm};
   endfunction

endpackage

// File: rtl/op_sequencer_if.sv
// -----------------------------------------------------------------------------
// op_sequencer_if
// Bundles the instruction handshake, the register-bank read bus and the
// writeback/status outputs of op_sequencer.
//   master : instruction source + register bank (drives instruction, reg_flat)
//   slave  : the sequencer (drives in_ready, wb_*, flags, done, illegal)
// -----------------------------------------------------------------------------
interface op_sequencer_if;

   logic                                             in_valid;
   logic                                             in_ready;
   logic [op_defs_pkg::OPW-1:0]                      in_op;
   logic [op_defs_pkg::IDXW-1:0]                     in_rdest;
   logic [op_defs_pkg::IDXW-1:0]                     in_rsrc;
   logic [op_defs_pkg::IMMW-1:0]                     in_imm;
   logic [op_defs_pkg::NREG*op_defs_pkg::DW-1:0]     reg_flat;
   logic [op_defs_pkg::DW-1:0]                       wb_data;
   logic [op_defs_pkg::NREG-1:0]                     wb_onehot;
   logic [op_defs_pkg::NFLAG-1:0]                    flags;
   logic                                             done;
   logic                                             illegal;

   modport master (
      output in_valid, in_op, in_rdest, in_rsrc, in_imm, reg_flat,
      input  in_ready, wb_data, wb_onehot, flags, done, illegal
   );

   modport slave (
      input  in_valid, in_op, in_rdest, in_rsrc, in_imm, reg_flat,
      output in_ready, wb_data, wb_onehot, flags, done, illegal
   );

endinterface

// File: rtl/alu16.sv
// -----------------------------------------------------------------------------
// alu16
// Purely combinational ALU for op_sequencer.
//   a, b      : operands (A = r[rdest], B = r[rsrc] or extended immediate)
//   op        : opcode
//   flags_in  : current {C,L,F,Z,N}
//   result    : op result (don't-care for illegal opcodes)
//   flags_out : next flags; every flag the op does not define is passed through
// -----------------------------------------------------------------------------
module alu16
   import op_defs_pkg::*;
(
   input  logic [DW-1:0]    a,
   input  logic [DW-1:0]    b,
   input  logic [OPW-1:0]   op,
   input  logic [NFLAG-1:0] flags_in,
   output logic [DW-1:0]    result,
   output logic [NFLAG-1:0] flags_out
);

   logic [DW:0]  sum;     // MSB is carry out
   logic [DW:0]  diff;    // MSB is borrow (A < B unsigned)
   logic [3:0]   rshamt;  // low nibble of -B; only these bits of the negation are needed

   assign sum    = {1'b0, a} + {1'b0, b};
   assign diff   = {1'b0, a} - {1'b0, b};
   assign rshamt = 4'd0 - b[3:0];

   // NOTE: every output is given a default at the top of the always_comb;
   // a path through the case that skipped an assignment would infer a latch.
   always_comb begin
      result    = '0;
      flags_out = flags_in;
      case (op)
         OP_ADD, OP_ADDI: begin
            result            = sum[DW-1:0];
            flags_out[FLAG_C] = sum[DW];
            flags_out[FLAG_F] = (a[DW-1] == b[DW-1]) && (sum[DW-1] != a[DW-1]);
         end
         OP_SUB, OP_SUBI: begin
            result            = diff[DW-1:0];
            flags_out[FLAG_C] = diff[DW];
            flags_out[FLAG_F] = (a[DW-1] != b[DW-1]) && (diff[DW-1] != a[DW-1]);
         end
         OP_CMP, OP_CMPI: begin
            result            = diff[DW-1:0];
            flags_out[FLAG_Z] = (a == b);
            flags_out[FLAG_N] = ($signed(a) < $signed(b));
            flags_out[FLAG_L] = diff[DW];
         end
         OP_AND:           result = a & b;
         OP_OR:            result = a | b;
         OP_XOR:           result = a ^ b;
         OP_MOV, OP_MOVI:  result = b;
         // Negative B shifts right by |B| (logical); otherwise left by B[3:0].
         OP_LSH, OP_LSHI:  result = b[DW-1] ? (a >> rshamt) : (a << b[3:0]);
         default:          result = '0;
      endcase
   end

endmodule

// File: rtl/op_sequencer.sv
// -----------------------------------------------------------------------------
// op_sequencer
// Four-state execute/writeback controller in front of a 16-entry register
// bank. One instruction is accepted per handshake in IDLE and walks through
// FETCH (operand read), EXEC (result + flags latched) and WB (bank write).
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : op_sequencer_if.slave -- instruction handshake, reg_flat read bus,
//           wb_data / wb_onehot write bus, flags, done and illegal pulses
// -----------------------------------------------------------------------------
module op_sequencer
   import op_defs_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   op_sequencer_if.slave  bus
);

   state_t              state_q, state_d;
   logic [OPW-1:0]      op_q;
   logic [IDXW-1:0]     rdest_q;
   logic [IDXW-1:0]     rsrc_q;
   logic [IMMW-1:0]     imm_q;
   logic [DW-1:0]       a_q, b_q;
   logic [DW-1:0]       result_q;
   logic [NFLAG-1:0]    flags_q;

   logic [DW-1:0]       alu_result;
   logic [NFLAG-1:0]    alu_flags;

   alu16 u_alu (
      .a         (a_q),
      .b         (b_q),
      .op        (op_q),
      .flags_in  (flags_q),
      .result    (alu_result),
      .flags_out (alu_flags)
   );

   // ---------------------------------------------------------------- FSM
   // NOTE: state and datapath registers use non-blocking assignments so every
   // flop samples pre-edge values; blocking here would create ordering races.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.in_valid) state_d = S_FETCH;
         S_FETCH: state_d = S_EXEC;
         S_EXEC:  state_d = S_WB;
         S_WB:    state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ----------------------------------------------------------- datapath
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q     <= '0;
         rdest_q  <= '0;
         rsrc_q   <= '0;
         imm_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (bus.in_valid) begin
               op_q    <= bus.in_op;
               rdest_q <= bus.in_rdest;
               rsrc_q  <= bus.in_rsrc;
               imm_q   <= bus.in_imm;
            end
            S_FETCH: begin
               a_q <= bus.reg_flat[DW*rdest_q +: DW];
               b_q <= is_imm(op_q) ? ext_imm(op_q, imm_q)
                                   : bus.reg_flat[DW*rsrc_q +: DW];
            end
            S_EXEC: begin
               result_q <= alu_result;
               flags_q  <= alu_flags;  // illegal ops pass flags through unchanged
            end
            default: ;
         endcase
      end
   end

   // ------------------------------------------------------------ outputs
   // All writeback-side outputs are gated by the WB state so they are zero
   // in every other cycle, including immediately on reset.
   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.done      = (state_q == S_WB);
   assign bus.illegal   = bus.done && is_illegal(op_q);
   assign bus.wb_data   = bus.done ? result_q : '0;
   assign bus.wb_onehot = (bus.done && is_write(op_q)) ? (NREG'(1) << rdest_q) : '0;
   assign bus.flags     = flags_q;

endmodule

// File: tb/tb_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_op_sequencer
// Directed bench for op_sequencer. Inputs change 1 time unit after a rising
// edge and outputs are sampled at the same point, away from the active edge.
// Expected values below are hand-computed from the instruction semantics.
// -----------------------------------------------------------------------------
module tb_op_sequencer;
   import op_defs_pkg::*;

   logic clk;
   logic reset;
   int   total = 0;
   int   bad   = 0;
   int   done_cnt = 0;
   int   acc_cnt  = 0;
   logic wr_seen  = 1'b0;

   op_sequencer_if bus ();

   op_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Event monitors, sampled mid-cycle on the falling edge.
   always @(negedge clk) begin
      if (bus.done === 1'b1) done_cnt++;
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) acc_cnt++;
      if (bus.wb_onehot !== '0) wr_seen = 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_reg(input int idx, input logic [15:0] val);
      bus.reg_flat[16*idx +: 16] = val;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one instruction in IDLE and advance to its WB cycle.
   task automatic issue(input string tag, input logic [3:0] op, input logic [3:0] rd,
                        input logic [3:0] rs, input logic [7:0] imm);
      bus.in_op    = op;
      bus.in_rdest = rd;
      bus.in_rsrc  = rs;
      bus.in_imm   = imm;
      bus.in_valid = 1'b1;
      step();                                  // accept edge -> FETCH
      bus.in_valid = 1'b0;
      check({tag, "_busy_ready"}, 32'(bus.in_ready), 32'd0);
      step();                                  // EXEC
      check({tag, "_exec_done"}, 32'(bus.done), 32'd0);
      step();                                  // WB
   endtask

   // Checks made in WB, then one more step back to IDLE.
   task automatic wb_expect(input string tag, input logic [15:0] onehot,
                            input logic chk_data, input logic [15:0] data,
                            input logic [4:0] flg, input logic ill);
      check({tag, "_onehot"}, 32'(bus.wb_onehot), 32'(onehot));
      if (chk_data) check({tag, "_data"}, 32'(bus.wb_data), 32'(data));
      check({tag, "_flags"}, 32'(bus.flags), 32'(flg));
      check({tag, "_done"}, 32'(bus.done), 32'd1);
      check({tag, "_illegal"}, 32'(bus.illegal), 32'(ill));
      step();
      check({tag, "_idle_ready"}, 32'(bus.in_ready), 32'd1);
      check({tag, "_idle_data"}, 32'(bus.wb_data), 32'd0);
      check({tag, "_idle_done"}, 32'(bus.done), 32'd0);
   endtask

   initial begin
      int d0, a0;
      bus.in_valid = 1'b0;
      bus.in_op    = '0;
      bus.in_rdest = '0;
      bus.in_rsrc  = '0;
      bus.in_imm   = '0;
      bus.reg_flat = '0;
      reset        = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready",   32'(bus.in_ready),  32'd1);
      check("rst_onehot",  32'(bus.wb_onehot), 32'd0);
      check("rst_data",    32'(bus.wb_data),   32'd0);
      check("rst_flags",   32'(bus.flags),     32'd0);
      check("rst_done",    32'(bus.done),      32'd0);
      check("rst_illegal", 32'(bus.illegal),   32'd0);
      reset = 1'b0;
      step();

      // ADD overflow into the sign bit: F=1, C=0.
      set_reg(3, 16'h7FFF); set_reg(4, 16'h0001);
      d0 = done_cnt;
      issue("add", OP_ADD, 4'd3, 4'd4, 8'h00);
      wb_expect("add", 16'h0008, 1'b1, 16'h8000, 5'b00100, 1'b0);
      check("add_done_once", 32'(done_cnt - d0), 32'd1);

      // SUBI 0 - 1: borrow, no overflow.
      set_reg(2, 16'h0000);
      issue("subi", OP_SUBI, 4'd2, 4'd0, 8'h01);
      wb_expect("subi", 16'h0004, 1'b1, 16'hFFFF, 5'b10000, 1'b0);

      // ADDI with imm 0xFF must add 0xFFFF (sign extension).
      set_reg(2, 16'h0010);
      issue("addi", OP_ADDI, 4'd2, 4'd0, 8'hFF);
      wb_expect("addi", 16'h0004, 1'b1, 16'h000F, 5'b10000, 1'b0);

      // 0x8000 + 0x8000: carry and overflow both set.
      set_reg(7, 16'h8000); set_reg(8, 16'h8000);
      issue("add2", OP_ADD, 4'd7, 4'd8, 8'h00);
      wb_expect("add2", 16'h0080, 1'b1, 16'h0000, 5'b10100, 1'b0);

      // CMP -1 vs 1: N=1, L=0, Z=0, C/F held at 1.
      set_reg(5, 16'hFFFF); set_reg(6, 16'h0001);
      issue("cmp", OP_CMP, 4'd5, 4'd6, 8'h00);
      wb_expect("cmp", 16'h0000, 1'b0, 16'h0000, 5'b10101, 1'b0);

      // CMPI equal operands (imm sign-extends to 0xFFFF).
      issue("cmpi", OP_CMPI, 4'd5, 4'd0, 8'hFF);
      wb_expect("cmpi", 16'h0000, 1'b0, 16'h0000, 5'b10110, 1'b0);

      // Shifts: left by 4, right by 4 (B=-4), LSHI zero-extends 0xFC -> left 12.
      set_reg(9, 16'h0081); set_reg(10, 16'h0004);
      issue("lsh_l", OP_LSH, 4'd9, 4'd10, 8'h00);
      wb_expect("lsh_l", 16'h0200, 1'b1, 16'h0810, 5'b10110, 1'b0);
      set_reg(10, 16'hFFFC);
      issue("lsh_r", OP_LSH, 4'd9, 4'd10, 8'h00);
      wb_expect("lsh_r", 16'h0200, 1'b1, 16'h0008, 5'b10110, 1'b0);
      issue("lshi", OP_LSHI, 4'd9, 4'd0, 8'hFC);
      wb_expect("lshi", 16'h0200, 1'b1, 16'h1000, 5'b10110, 1'b0);

      // MOVI zero-extends; XOR leaves flags alone.
      issue("movi", OP_MOVI, 4'd11, 4'd0, 8'h80);
      wb_expect("movi", 16'h0800, 1'b1, 16'h0080, 5'b10110, 1'b0);
      set_reg(12, 16'hF0F0); set_reg(13, 16'hFF00);
      issue("xor", OP_XOR, 4'd12, 4'd13, 8'h00);
      wb_expect("xor", 16'h1000, 1'b1, 16'h0FF0, 5'b10110, 1'b0);

      // Illegal opcode 14: pulse, no write, flags unchanged.
      issue("ill", 4'd14, 4'd1, 4'd2, 8'h33);
      wb_expect("ill", 16'h0000, 1'b0, 16'h0000, 5'b10110, 1'b1);

      // in_valid held for 10 edges: accepts on edges 0, 4, 8.
      d0 = done_cnt;
      a0 = acc_cnt;
      bus.in_op = OP_MOV; bus.in_rdest = 4'd1; bus.in_rsrc = 4'd2;
      bus.in_valid = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (4) step();
      check("hold_accepts", 32'(acc_cnt - a0), 32'd3);
      check("hold_dones", 32'(done_cnt - d0), 32'd3);
      check("hold_ready", 32'(bus.in_ready), 32'd1);

      // Reset during EXEC of MOVI r1, 0x55: no write ever, outputs zero at once.
      d0 = done_cnt;
      bus.in_op = OP_MOVI; bus.in_rdest = 4'd1; bus.in_imm = 8'h55;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      step();                                  // EXEC
      wr_seen = 1'b0;
      #2 reset = 1'b1;
      #1;
      check("mid_rst_onehot",  32'(bus.wb_onehot), 32'd0);
      check("mid_rst_data",    32'(bus.wb_data),   32'd0);
      check("mid_rst_flags",   32'(bus.flags),     32'd0);
      check("mid_rst_done",    32'(bus.done),      32'd0);
      check("mid_rst_illegal", 32'(bus.illegal),   32'd0);
      check("mid_rst_ready",   32'(bus.in_ready),  32'd1);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      check("post_rst_ready", 32'(bus.in_ready), 32'd1);
      repeat (5) step();
      check("post_rst_no_write", 32'(wr_seen), 32'd0);
      check("post_rst_no_done", 32'(done_cnt - d0), 32'd0);
      check("post_rst_ready2", 32'(bus.in_ready), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
